// File: rtl/hash_target_compare_if.sv
// Digest hand-off bundle between the SHA256d core and the target comparator.
// The upstream stage (master) presents a digest, its nonce and the current
// full target; the comparator (slave) accepts them with a valid/ready handshake.
interface hash_target_compare_if;
    logic         hash_valid_i;
    logic         hash_ready_o;
    logic [255:0] hash_i;
    logic [31:0]  nonce_i;
    logic [255:0] target_i;

    modport master (
        output hash_valid_i,
        output hash_i,
        output nonce_i,
        output target_i,
        input  hash_ready_o
    );

    modport slave (
        input  hash_valid_i,
        input  hash_i,
        input  nonce_i,
        input  target_i,
        output hash_ready_o
    );
endinterface

// File: rtl/hash_target_compare.sv
// Decides whether a double-SHA256 digest meets the full target (hash <= target).
// The compare walks the 256-bit values one slice at a time, most significant
// slice first, and stops at the first slice that differs. Winning nonces and
// a saturating hit count are kept for the status registers.
module hash_target_compare #(
    parameter int WORD_W        = 32,
    parameter int REVERSE_BYTES = 1,
    parameter int COUNT_W       = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    hash_target_compare_if.slave hif,
    input  logic                 clear_i,
    output logic                 result_valid_o,
    output logic                 result_hit_o,
    output logic                 found_valid_o,
    output logic [31:0]          found_nonce_o,
    output logic [COUNT_W-1:0]   hit_count_o
);

    localparam int NUM_WORDS = 256 / WORD_W;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMP  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // The digest arrives little-endian; byte k of the compared value is byte 31-k of the input.
    function automatic logic [255:0] byte_rev(input logic [255:0] v);
        logic [255:0] r;
        r = 256'd0;
        for (int k = 0; k < 32; k++) begin
            r[8*k +: 8] = v[8*(31-k) +: 8];
        end
        return r;
    endfunction

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [255:0]       hash_q, hash_d;
    logic [255:0]       target_q, target_d;
    logic [31:0]        nonce_q, nonce_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;
    logic               hit_q, hit_d;
    logic               found_valid_q, found_valid_d;
    logic [31:0]        found_nonce_q, found_nonce_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic [255:0]       hash_in_s;
    logic [WORD_W-1:0]  h_word_s;
    logic [WORD_W-1:0]  t_word_s;
    logic               last_s;

    assign hash_in_s = (REVERSE_BYTES != 0) ? byte_rev(hif.hash_i) : hif.hash_i;

    // The latched hash/target are shifted left after each equal slice, so the
    // slice under test is always the top WORD_W bits of the working registers.
    assign h_word_s = hash_q[255 -: WORD_W];
    assign t_word_s = target_q[255 -: WORD_W];
    assign last_s   = (idx_q == IDX_W'(NUM_WORDS - 1));

    assign hif.hash_ready_o = ready_q;
    assign result_valid_o   = valid_q;
    assign result_hit_o     = hit_q;
    assign found_valid_o    = found_valid_q;
    assign found_nonce_o    = found_nonce_q;
    assign hit_count_o      = count_q;

    // Next-state logic: handshake, slice-by-slice compare, hit bookkeeping and clear.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        hash_d        = hash_q;
        target_d      = target_q;
        nonce_d       = nonce_q;
        ready_d       = ready_q;
        valid_d       = 1'b0;
        hit_d         = hit_q;
        found_valid_d = found_valid_q;
        found_nonce_d = found_nonce_q;
        count_d       = count_q;

        case (state_q)
            ST_IDLE: begin
                if (hif.hash_valid_i && ready_q) begin
                    hash_d   = hash_in_s;
                    target_d = hif.target_i;
                    nonce_d  = hif.nonce_i;
                    idx_d    = {IDX_W{1'b0}};
                    ready_d  = 1'b0;
                    state_d  = ST_CMP;
                end else begin
                    ready_d = 1'b1;
                end
            end
            ST_CMP: begin
                if (h_word_s > t_word_s) begin
                    hit_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end else if (h_word_s < t_word_s) begin
                    hit_d   = 1'b1;
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end else if (last_s) begin
                    // Every slice matched: equality meets the target.
                    hit_d   = 1'b1;
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idx_d    = idx_q + IDX_W'(1);
                    hash_d   = hash_q << WORD_W;
                    target_d = target_q << WORD_W;
                end
            end
            ST_DONE: begin
                if (hit_q) begin
                    found_nonce_d = nonce_q;
                    found_valid_d = 1'b1;
                    if (count_q != {COUNT_W{1'b1}}) begin
                        count_d = count_q + COUNT_W'(1);
                    end else begin
                        count_d = count_q;
                    end
                end else begin
                    found_nonce_d = found_nonce_q;
                end
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        // Clear overrides a coincident hit update; the result pulse still reports the hit.
        if (clear_i) begin
            count_d       = {COUNT_W{1'b0}};
            found_valid_d = 1'b0;
        end else begin
            found_valid_d = found_valid_d;
        end
    end

    // State and output registers with synchronous reset; reset also aborts any compare.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q       <= ST_IDLE;
            idx_q         <= {IDX_W{1'b0}};
            hash_q        <= 256'd0;
            target_q      <= 256'd0;
            nonce_q       <= 32'd0;
            ready_q       <= 1'b1;
            valid_q       <= 1'b0;
            hit_q         <= 1'b0;
            found_valid_q <= 1'b0;
            found_nonce_q <= 32'd0;
            count_q       <= {COUNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            hash_q        <= hash_d;
            target_q      <= target_d;
            nonce_q       <= nonce_d;
            ready_q       <= ready_d;
            valid_q       <= valid_d;
            hit_q         <= hit_d;
            found_valid_q <= found_valid_d;
            found_nonce_q <= found_nonce_d;
            count_q       <= count_d;
        end
    end

endmodule

// File: tb/tb_hash_target_compare.sv
// Self-checking bench for hash_target_compare: directed corner cases followed
// by randomized digests checked against a whole-value reference model.
module tb_hash_target_compare;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          res_valid;
    logic          res_hit;
    logic          found_valid;
    logic [31:0]   found_nonce;
    logic [CW-1:0] hit_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    logic        m_found;
    logic [31:0] m_nonce;
    int          m_count;
    logic        m_hit;

    hash_target_compare_if hif();

    hash_target_compare #(
        .WORD_W(32),
        .REVERSE_BYTES(1),
        .COUNT_W(CW)
    ) u_dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .hif           (hif.slave),
        .clear_i       (clear),
        .result_valid_o(res_valid),
        .result_hit_o  (res_hit),
        .found_valid_o (found_valid),
        .found_nonce_o (found_nonce),
        .hit_count_o   (hit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk_state(input string tag);
        chk({tag, "_found_valid"}, 256'(found_valid), 256'(m_found));
        chk({tag, "_found_nonce"}, 256'(found_nonce), 256'(m_nonce));
        chk({tag, "_hit_count"},   256'(hit_count),   256'(m_count));
    endtask

    // One full transaction. c is the value compared against the target; the
    // digest on the bus is its byte reversal.
    task automatic run_txn(input logic [255:0] c, input logic [255:0] t,
                           input logic [31:0] nonce, input bit clr_at_done);
        logic [255:0] diff;
        logic         exp_hit;
        int           exp_lat;
        int           lat;
        int           p;
        exp_hit = (c <= t);
        diff    = c ^ t;
        if (diff == 256'd0) begin
            exp_lat = 9;
        end else begin
            p = 255;
            while (!diff[p]) p--;
            exp_lat = (255 - p) / 32 + 2;
        end

        @(negedge clk);
        chk("ready_idle", 256'(hif.hash_ready_o), 256'd1);
        hif.hash_valid_i = 1'b1;
        hif.hash_i       = {<<8{c}};
        hif.target_i     = t;
        hif.nonce_i      = nonce;
        @(posedge clk);
        #1;
        hif.hash_valid_i = 1'b0;
        hif.hash_i       = rnd256();
        hif.target_i     = rnd256();
        hif.nonce_i      = $urandom;

        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (res_valid) break;
        end
        chk("latency", 256'(lat), 256'(exp_lat));
        chk("result_hit", 256'(res_hit), 256'(exp_hit));
        if (clr_at_done) clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;

        m_hit = exp_hit;
        if (exp_hit) begin
            m_nonce = nonce;
            m_found = 1'b1;
            if (m_count < (1 << CW) - 1) m_count++;
        end
        if (clr_at_done) begin
            m_count = 0;
            m_found = 1'b0;
        end
        chk("valid_pulse_end", 256'(res_valid), 256'd0);
        chk("hit_held", 256'(res_hit), 256'(m_hit));
        chk("ready_after", 256'(hif.hash_ready_o), 256'd1);
        chk_state("post");
    endtask

    initial begin
        logic [255:0] tgt;
        logic [255:0] c;
        int           pulses;
        int           w;

        hif.hash_valid_i = 1'b0;
        hif.hash_i       = 256'd0;
        hif.target_i     = 256'd0;
        hif.nonce_i      = 32'd0;
        m_found = 1'b0;
        m_nonce = 32'd0;
        m_count = 0;
        m_hit   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 256'(hif.hash_ready_o), 256'd1);
        chk("rst_valid", 256'(res_valid), 256'd0);
        chk("rst_hit", 256'(res_hit), 256'd0);
        chk_state("rst");

        // Bitcoin genesis-difficulty target
        tgt = 256'hFFFF << 208;
        run_txn(256'h1234 << 192, tgt, 32'hCAFE_0001, 1'b0);
        run_txn({32'hFFFF_FFFF, 224'd0}, tgt, 32'hCAFE_0002, 1'b0);
        run_txn(tgt, tgt, 32'hCAFE_0003, 1'b0);
        run_txn(256'd0, 256'd0, 32'hCAFE_0004, 1'b0);
        run_txn(256'd1, 256'd0, 32'hCAFE_0005, 1'b0);

        // Reset in the middle of a long compare
        @(negedge clk);
        hif.hash_valid_i = 1'b1;
        hif.hash_i       = {<<8{tgt}};
        hif.target_i     = tgt;
        hif.nonce_i      = 32'h0BAD_0BAD;
        @(posedge clk);
        #1;
        hif.hash_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_found = 1'b0;
        m_nonce = 32'd0;
        m_count = 0;
        m_hit   = 1'b0;
        chk("midrst_valid", 256'(res_valid), 256'd0);
        chk("midrst_ready", 256'(hif.hash_ready_o), 256'd1);
        chk("midrst_hit", 256'(res_hit), 256'd0);
        chk_state("midrst");
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (res_valid) pulses++;
        end
        chk("midrst_no_result", 256'(pulses), 256'd0);

        // Saturation and clear priority
        for (int i = 0; i < 4; i++) run_txn(256'd5, 256'd9, 32'h5A00_0000 + 32'(i), 1'b0);
        run_txn(256'd5, 256'd9, 32'h5A00_0010, 1'b1);

        // Clear while idle leaves found_nonce alone
        run_txn(256'd1, 256'd2, 32'h7700_0001, 1'b0);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_count = 0;
        m_found = 1'b0;
        chk_state("idle_clear");

        // Randomized digests
        for (int n = 0; n < 40; n++) begin
            tgt = rnd256();
            if ($urandom_range(0, 1) == 0) tgt = tgt >> $urandom_range(0, 64);
            case ($urandom_range(0, 3))
                0: c = rnd256();
                1: c = tgt;
                2: begin
                    c = tgt;
                    w = $urandom_range(0, 7);
                    c[32*w +: 32] = c[32*w +: 32] ^ (32'($urandom_range(1, 255)) << $urandom_range(0, 24));
                end
                default: c = (tgt != 256'd0) ? tgt - 256'd1 : 256'd0;
            endcase
            run_txn(c, tgt, $urandom, ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
